// File: rtl/key_pulse_gen.sv
// key_pulse_gen: front-panel key conditioning.
// Each of the five raw push-buttons goes through its own channel:
//   - a 2-flop synchroniser
//   - a debounce counter
//   - a one-clock press-pulse generator
// The channels are identical and fully independent.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   key_*_in             raw asynchronous button inputs
//   RESTARTdown..        registered one-cycle press pulses
//   DownDown
//   key_level[4:0]       debounced levels, 1 = pressed, {restart,left,right,up,down}
//   any_down             OR of the five press pulses

// Per-key channel.
// A level change is accepted only after s2 has differed from the
// accepted level for CNT_MAX consecutive cycles. A press raises pulse
// for one cycle; a release is silent.
module key_pulse_chan #(
  parameter int CNT_W      = 20,
  parameter int CNT_MAX    = 1_000_000,
  parameter bit KEY_ACTIVE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  // Normalise before the synchroniser so everything downstream is 1 = pressed.
  logic             p;
  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  assign p = KEY_ACTIVE ? raw : ~raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= p;
      s2    <= s1;
      pulse <= 1'b0;
      if (s2 == level) begin
        // Any return to the accepted level restarts the qualification window.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s2;
        cnt   <= '0;
        pulse <= s2;
      end else begin
        // The counter stops at CNT_LAST, so it never wraps.
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module key_pulse_gen #(
  parameter int CNT_W      = 20,
  parameter int CNT_MAX    = 1_000_000,
  parameter bit KEY_ACTIVE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_restart_in,
  input  logic       key_left_in,
  input  logic       key_right_in,
  input  logic       key_up_in,
  input  logic       key_down_in,
  output logic       RESTARTdown,
  output logic       LeftDown,
  output logic       RightDown,
  output logic       UpDown,
  output logic       DownDown,
  output logic [4:0] key_level,
  output logic       any_down
);
  localparam int NUM_KEYS = 5;

  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] pulse;

  // Bit order {restart, left, right, up, down} matches key_level.
  assign raw = {key_restart_in, key_left_in, key_right_in, key_up_in, key_down_in};

  key_pulse_chan #(
    .CNT_W     (CNT_W),
    .CNT_MAX   (CNT_MAX),
    .KEY_ACTIVE(KEY_ACTIVE)
  ) u_chan [NUM_KEYS-1:0] (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw),
    .level(key_level),
    .pulse(pulse)
  );

  assign RESTARTdown = pulse[4];
  assign LeftDown    = pulse[3];
  assign RightDown   = pulse[2];
  assign UpDown      = pulse[1];
  assign DownDown    = pulse[0];
  assign any_down    = |pulse;
endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen.
// Two instances share the clock and reset, both with CNT_MAX=4:
//   u_a  active-high keys
//   u_b  active-low keys
// Edge numbering restarts at 1 for the first edge after clear_stats;
// the expected press latency is CNT_MAX+2 = 6 edges.
module tb_key_pulse_gen;
  localparam int CW = 4;
  localparam int CM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: active-high keys
  logic a_rs = 0, a_l = 0, a_r = 0, a_u = 0, a_d = 0;
  logic a_RS, a_L, a_R, a_U, a_D, a_any;
  logic [4:0] a_lvl;

  // DUT B: active-low keys, so idle inputs sit at 1
  logic b_rs = 1, b_l = 1, b_r = 1, b_u = 1, b_d = 1;
  logic b_RS, b_L, b_R, b_U, b_D, b_any;
  logic [4:0] b_lvl;

  key_pulse_gen #(.CNT_W(CW), .CNT_MAX(CM), .KEY_ACTIVE(1'b1)) u_a (
    .clk(clk), .rst(rst),
    .key_restart_in(a_rs), .key_left_in(a_l), .key_right_in(a_r),
    .key_up_in(a_u), .key_down_in(a_d),
    .RESTARTdown(a_RS), .LeftDown(a_L), .RightDown(a_R), .UpDown(a_U), .DownDown(a_D),
    .key_level(a_lvl), .any_down(a_any));

  key_pulse_gen #(.CNT_W(CW), .CNT_MAX(CM), .KEY_ACTIVE(1'b0)) u_b (
    .clk(clk), .rst(rst),
    .key_restart_in(b_rs), .key_left_in(b_l), .key_right_in(b_r),
    .key_up_in(b_u), .key_down_in(b_d),
    .RESTARTdown(b_RS), .LeftDown(b_L), .RightDown(b_R), .UpDown(b_U), .DownDown(b_D),
    .key_level(b_lvl), .any_down(b_any));

  wire [4:0] pa = {a_RS, a_L, a_R, a_U, a_D};
  wire [4:0] pb = {b_RS, b_L, b_R, b_U, b_D};

  int errors = 0;
  int checks = 0;

  // Per-window observations of the selected DUT
  bit sel = 0;
  int ecount;
  int pcnt [5];
  int pedge[5];
  int lrise[5];
  int lfall[5];
  int anyc;
  int simul;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic clear_stats();
    ecount = 0;
    anyc   = 0;
    simul  = 0;
    for (int i = 0; i < 5; i++) begin
      pcnt[i]  = 0;
      pedge[i] = -1;
      lrise[i] = -1;
      lfall[i] = -1;
    end
  endtask

  // Advance n clocks, sampling #1 after each rising edge.
  task automatic run(input int n);
    logic [4:0] pv, lv;
    logic av;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      ecount++;
      pv = sel ? pb    : pa;
      lv = sel ? b_lvl : a_lvl;
      av = sel ? b_any : a_any;
      for (int i = 0; i < 5; i++) begin
        if (pv[i]) begin
          pcnt[i]++;
          if (pedge[i] < 0) pedge[i] = ecount;
        end
        if (lv[i] && lrise[i] < 0) lrise[i] = ecount;
        if (!lv[i] && lrise[i] >= 0 && lfall[i] < 0) lfall[i] = ecount;
      end
      if (av) anyc++;
      if (pv[4] && pv[2] && av) simul++;
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_a_pulse", {27'd0, pa}, 0);
    chk("rst_a_level", {27'd0, a_lvl}, 0);
    chk("rst_b_pulse", {27'd0, pb}, 0);
    chk("rst_b_level", {27'd0, b_lvl}, 0);
    run(2);
    rst = 1'b0;
    run(3);
    chk("idle_a_any", {31'd0, a_any}, 0);

    // 1: clean press on left
    clear_stats();
    a_l = 1;
    run(20);
    chk("s1_left_cnt",   pcnt[3], 1);
    chk("s1_left_edge",  pedge[3], 6);
    chk("s1_lvl_rise",   lrise[3], 6);
    chk("s1_lvl_held",   lfall[3], -1);
    chk("s1_others",     pcnt[4] + pcnt[2] + pcnt[1] + pcnt[0], 0);
    chk("s1_any_cnt",    anyc, 1);
    a_l = 0;
    run(10);
    chk("s1_released", {27'd0, a_lvl}, 0);

    // 2: bounce on up, then a short release glitch
    clear_stats();
    a_u = 1; run(2);
    a_u = 0; run(2);
    a_u = 1; run(2);
    a_u = 0; run(2);
    a_u = 1; run(10);
    chk("s2_up_cnt",  pcnt[1], 1);
    chk("s2_up_edge", pedge[1], 14);
    clear_stats();
    a_u = 0; run(3);
    a_u = 1; run(10);
    chk("s2_glitch_nofall",  lfall[1], -1);
    chk("s2_glitch_nopulse", pcnt[1], 0);
    chk("s2_glitch_level",   {31'd0, a_lvl[1]}, 1);
    a_u = 0;
    run(10);

    // 3: press, release, re-press on down
    clear_stats();
    a_d = 1; run(10);
    a_d = 0; run(10);
    a_d = 1; run(10);
    chk("s3_down_cnt",  pcnt[0], 2);
    chk("s3_down_edge", pedge[0], 6);
    chk("s3_lvl_fall",  lfall[0], 16);
    a_d = 0;
    run(10);

    // 4: restart and right together
    clear_stats();
    a_rs = 1;
    a_r  = 1;
    run(10);
    chk("s4_simul",     simul, 1);
    chk("s4_rs_edge",   pedge[4], 6);
    chk("s4_r_edge",    pedge[2], 6);
    chk("s4_any_cnt",   anyc, 1);
    a_rs = 0;
    a_r  = 0;
    run(10);

    // 5: reset in the middle of a left qualification
    clear_stats();
    a_l = 1;
    run(2);
    rst = 1'b1;
    #1;
    chk("s5_rst_pulse", {27'd0, pa}, 0);
    chk("s5_rst_level", {27'd0, a_lvl}, 0);
    run(2);
    chk("s5_rst_pulse2", pcnt[3], 0);
    chk("s5_rst_level2", {27'd0, a_lvl}, 0);
    rst = 1'b0;
    clear_stats();
    run(10);
    chk("s5_left_cnt",  pcnt[3], 1);
    chk("s5_left_edge", pedge[3], 6);
    a_l = 0;
    run(10);

    // 6: active-low instance
    sel = 1;
    clear_stats();
    run(10);
    chk("s6_idle_pulses", pcnt[4] + pcnt[3] + pcnt[2] + pcnt[1] + pcnt[0], 0);
    chk("s6_idle_level",  {27'd0, b_lvl}, 0);
    clear_stats();
    b_u = 0;
    run(20);
    chk("s6_up_cnt",  pcnt[1], 1);
    chk("s6_up_edge", pedge[1], 6);
    chk("s6_up_lvl",  lrise[1], 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_pulse_gen.md
# key_pulse_gen

Input conditioning stage for the vision-test front panel. Takes the five raw mechanical push-buttons (restart, left, right, up, down), synchronises and debounces each one, and emits one-clock press pulses. These pulses drive the test state machine's `RESTARTdown`, `LeftDown`, `RightDown`, `UpDown` and `DownDown` inputs, which require exactly one pulse per physical press. It also provides debounced key levels and an any-key strobe for the random-number and status logic.

## Interface

**Parameters**
- `CNT_W`, default 20: debounce counter width.
- `CNT_MAX`, default 1_000_000: number of consecutive stable cycles required before a level change is accepted. This is 20 ms at 50 MHz. Legal range is 2 .. 2^CNT_W−1.
- `KEY_ACTIVE`, default 1: raw level meaning "pressed". 1 means active-high keys; 0 means active-low keys.

**Ports**
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `key_restart_in`, `key_left_in`, `key_right_in`, `key_up_in`, `key_down_in`  in  1 each  raw asynchronous button inputs.
- `RESTARTdown`, `LeftDown`, `RightDown`, `UpDown`, `DownDown`  out  1 each  registered one-cycle press pulses.
- `key_level`  out  5  debounced pressed levels, normalised so 1 = pressed. Bit order is {restart, left, right, up, down}, i.e. bit4 = restart and bit0 = down.
- `any_down`  out  1  OR of the five press pulses.

## Operation

The five keys use identical, fully independent channels. There is no priority or masking between keys.

**Per-channel state**
- `s1`, `s2`: 2-flop synchroniser, holding the normalised level `p = KEY_ACTIVE ? raw : ~raw` (normalisation applied before `s1`).
- `cnt[CNT_W-1:0]`: debounce counter.
- `stable`: drives the corresponding `key_level` bit.
- `pulse`: drives the corresponding press-pulse output.

**Counter and level update, every clock**
- `s2 == stable`: `cnt <= 0`.
- `s2 != stable` and `cnt < CNT_MAX-1`: `cnt <= cnt+1`.
- `s2 != stable` and `cnt == CNT_MAX-1`:
  - `stable <= s2`
  - `cnt <= 0`
  - `pulse <= s2` (1 only on an accepted press)

**Pulse behaviour**
- In every other cycle `pulse <= 0`, so a pulse is exactly one cycle wide.
- An accepted release produces no pulse.
- A held key produces one pulse only, with no auto-repeat.

**Outputs**
- `any_down` is combinational: the OR of the five `pulse` registers.

**Reset**
- Clears `s1`, `s2`, `cnt`, `stable` and `pulse` in all channels, i.e. the "released" state.
- All outputs are 0 during and immediately after reset.
- A key held through reset release is treated as a new press and yields one pulse after the normal latency.

## Timing

**Press latency**
- Let edge 1 be the first clock edge that samples the new raw level into `s1`.
- `s2` updates at edge 2.
- The counter runs over edges 3 .. CNT_MAX+1.
- `stable` and `pulse` update at edge CNT_MAX+2.
- The pulse is high for exactly the cycle following edge CNT_MAX+2.

**Release latency**
- Same as press: `key_level` falls at edge CNT_MAX+2, with no pulse.

**Glitch rejection**
- Any return of `s2` to `stable` before the count completes resets `cnt` to 0.
- A bounce shorter than CNT_MAX cycles therefore never changes `stable`.

**Repeated presses**
- Minimum press-to-press spacing that yields two pulses: CNT_MAX cycles pressed, CNT_MAX released, CNT_MAX pressed.

**Simultaneous events**
- Keys qualifying on the same edge pulse in the same cycle.
- `any_down` is high for that single cycle.

**Counter range**
- `cnt` never exceeds CNT_MAX−1, so it never wraps.

## Test plan

Run with CNT_MAX=4, KEY_ACTIVE=1 unless noted.

1. **Clean press:** raise `key_left_in` and hold 20 cycles → `LeftDown` is high for exactly 1 cycle, following edge 6 after the rise; `key_level[3]` rises on the same edge and stays 1; all other outputs stay 0.
2. **Bounce:** toggle `key_up_in` 1-0-1-0 at 2-cycle spacing, then hold 1 for 10 cycles → exactly one `UpDown` pulse, 6 edges after the final rise. Release with a 3-cycle 0 then back to 1 → `key_level[1]` never falls and no second pulse.
3. **Release and re-press:** press `key_down_in` 10 cycles, release 10, press 10 → exactly two `DownDown` pulses; `key_level[0]` falls 6 edges after release.
4. **Simultaneous:** raise `key_restart_in` and `key_right_in` on the same cycle → `RESTARTdown`, `RightDown` and `any_down` are all high in the same single cycle.
5. **Reset mid-count:** press `key_left_in`, assert `rst` at cycle 3 for 2 cycles while holding the key → outputs are 0 during reset; one `LeftDown` pulse arrives 6 edges after the first post-reset edge.
6. **KEY_ACTIVE=0:** idle inputs held at 1 produce no outputs; driving `key_up_in` to 0 yields one `UpDown` pulse with the same latency as scenario 1.
